// File: rtl/hamming_pkg.sv
// Shared constants for the Hamming(12,8) serial link.
// The matching receiver uses the same state encoding and widths.
package hamming_pkg;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] START = 2'd1;
    localparam logic [1:0] DATA  = 2'd2;
    localparam logic [1:0] STOP  = 2'd3;

    localparam int CODE_W  = 12;
    localparam int DATA8_W = 8;

endpackage

// File: rtl/hamming_tx_baud.sv
// Bit-period counter: counts 0..CLKS_PER_BIT-1 while enabled and
// pulses bit_end_o on the last cycle of each bit.
module hamming_tx_baud
    import hamming_pkg::*;
#(
    parameter int CLKS_PER_BIT = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic clr_i,
    input  logic en_i,
    output logic bit_end_o
);

    localparam int CW = 8;
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // Not gated by clr_i: the top derives clr_i from bit_end_o.
    assign bit_end_o = en_i && (cnt_q == LAST);

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = bit_end_o ? '0 : cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/hamming_tx.sv
// Serial transmitter for Hamming codewords: start bit, DATA_W bits
// LSB first, stop bit, each held CLKS_PER_BIT cycles.
module hamming_tx
    import hamming_pkg::*;
#(
    parameter int DATA_W       = CODE_W,
    parameter int CLKS_PER_BIT = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] code_in,
    input  logic              code_valid,
    output logic              code_ready,
    output logic              tx,
    output logic              busy
);

    localparam int IDX_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_W - 1);

    logic [1:0]        state_q, state_d;
    logic              tx_q, tx_d;
    logic [DATA_W-1:0] shift_q, shift_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic              accept;
    logic              bit_end;

    // Ready in IDLE or on the last STOP cycle, so frames chain gap-free.
    assign code_ready = rst && ((state_q == IDLE) ||
                                ((state_q == STOP) && bit_end));
    assign accept     = code_valid && code_ready;
    assign busy       = (state_q != IDLE);
    assign tx         = tx_q;

    hamming_tx_baud #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud (
        .clk      (clk),
        .rst      (rst),
        .clr_i    (accept),
        .en_i     (busy),
        .bit_end_o(bit_end)
    );

    always_comb begin
        state_d = state_q;
        tx_d    = tx_q;
        shift_d = shift_q;
        idx_d   = idx_q;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = START;
                    tx_d    = 1'b0;
                    shift_d = code_in;
                    idx_d   = '0;
                end
            end
            START: begin
                if (bit_end) begin
                    state_d = DATA;
                    tx_d    = shift_q[0];
                    shift_d = shift_q >> 1;
                    idx_d   = '0;
                end
            end
            DATA: begin
                if (bit_end) begin
                    if (idx_q == LAST_IDX) begin
                        state_d = STOP;
                        tx_d    = 1'b1;
                    end else begin
                        tx_d    = shift_q[0];
                        shift_d = shift_q >> 1;
                        idx_d   = idx_q + 1'b1;
                    end
                end
            end
            STOP: begin
                if (bit_end) begin
                    if (accept) begin
                        state_d = START;
                        tx_d    = 1'b0;
                        shift_d = code_in;
                        idx_d   = '0;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                tx_d    = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            tx_q    <= 1'b1;
            shift_q <= '0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            tx_q    <= tx_d;
            shift_q <= shift_d;
            idx_q   <= idx_d;
        end
    end

endmodule
